bcd_time_counter: RTL
=====================

Name: bcd_time_counter

Overview:
- Downstream consumer of the 1 Hz slow clock from the clock divider.
- Keeps 24-hour wall time (HH:MM:SS) in packed BCD and accepts a time-set load.
- Flags midnight rollover and, optionally, an alarm match.
- Runs entirely on the 100 MHz system clock. The 1 Hz square wave is a sampled data input, never used as a clock.

Parameters:
SYNC_STAGES, 2, flip-flop stages synchronising sec_clk before edge detection (min 2)
RESET_HH, 8'h00, BCD hours value loaded on reset (must be valid BCD 00-23)

Ports:
clk  in  1  system clock, 100 MHz
reset  in  1  asynchronous, active-high
sec_clk  in  1  1 Hz square wave from divider; each rising edge = one second
hold  in  1  1 = freeze counting; edges arriving while high are dropped
set_load  in  1  one-cycle strobe: load set_hh/set_mm/set_ss
set_hh  in  8  BCD hours {tens[7:4], units[3:0]}
set_mm  in  8  BCD minutes
set_ss  in  8  BCD seconds
alarm_load  in  1  one-cycle strobe: capture alarm_hh/alarm_mm
alarm_hh  in  8  BCD alarm hours
alarm_mm  in  8  BCD alarm minutes
alarm_on  in  1  alarm arm switch
alarm_ack  in  1  clears alarm_ring
hours  out  8  current BCD hours
minutes  out  8  current BCD minutes
seconds  out  8  current BCD seconds
sec_tick  out  1  one-cycle pulse per accepted second
day_pulse  out  1  one-cycle pulse on 23:59:59 -> 00:00:00
set_err  out  1  one-cycle pulse: set_load or alarm_load rejected
alarm_ring  out  1  alarm active (level)

Behaviour:
- Reset (async, active-high), applied at power-up or mid-operation:
  - hours = RESET_HH; minutes = seconds = 8'h00.
  - sec_tick, day_pulse, set_err, alarm_ring = 0.
  - Synchroniser and edge-detect history = 0. Alarm registers = 00:00.
- Tick path:
  - sec_clk passes through SYNC_STAGES flops, then a history flop.
  - A rising edge (sync = 1, history = 0) forms an internal tick.
  - The time registers and sec_tick update on the clock edge after the tick is detected. Total latency from sec_clk rising to the count change is SYNC_STAGES+1 cycles.
- Counting on an accepted tick (hold = 0 and no set_load in the same cycle):
  - Seconds units increment 0-9. At 9: units -> 0, tens +1.
  - Seconds 59 -> 00, with a carry into minutes.
  - Minutes use the same rule, 59 -> 00, with a carry into hours.
  - Hours 09 -> 10, 19 -> 20, 23 -> 00.
  - 23:59:59 -> 00:00:00 asserts day_pulse in the same cycle as sec_tick.
- Nibble range: outputs never hold a units nibble > 9, a tens nibble > 5 (min/sec), or hours > 23.
- hold = 1:
  - Ticks are discarded, not queued.
  - sec_tick stays low.
  - The time is frozen.
- set_load validation:
  - Valid iff every nibble is in range: hh <= 23, mm <= 59, ss <= 59, all units <= 9.
  - Valid: time registers take the set values on the next edge. No sec_tick or day_pulse that cycle.
  - Invalid: registers unchanged; set_err pulses for one cycle.
- set_load coinciding with a tick: the load wins and the tick is dropped. set_load is honoured even while hold = 1.
- alarm_load:
  - Validated with the same rules (hh <= 23, mm <= 59).
  - Invalid: set_err pulses and the alarm registers are unchanged.
  - set_err is a single OR of both rejection sources.

Optional Feature:
- Macro: BCD_TIME_ALARM_EN
- Defined:
  - alarm_ring sets on the cycle the counter transitions to alarm_hh:alarm_mm:00 via a tick while alarm_on = 1. A set_load landing on that time does not ring.
  - alarm_ring clears on alarm_ack = 1 or alarm_on = 0.
  - If clear and set coincide, clear wins.
  - The ring does not auto-clear.
- Not defined:
  - Alarm registers and match logic are absent.
  - alarm_ring is tied to 0.
  - alarm_load validation and its set_err contribution are removed.
  - Alarm input ports remain and are ignored.

Test Plan:
- Reset with RESET_HH = 8'h00; toggle sec_clk 3 times -> outputs 00:00:03, three sec_tick pulses, each SYNC_STAGES+1 cycles after its sec_clk rise.
- set_load 23:59:58, then 2 ticks -> 23:59:59, then 00:00:00; day_pulse coincides with the second sec_tick only.
- set_load 24:00:00, then 12:60:00 -> set_err pulses twice, time unchanged. set_load 09:59:59 + tick -> 10:00:00.
- set_load 05:00:00 in the same cycle as an internal tick -> 05:00:00, no sec_tick. hold = 1 across 4 edges -> time frozen; release -> the next edge advances by exactly 1 s.
- Assert reset mid-count at 14:23:45 -> asynchronous return to RESET_HH:00:00; pulses low.
- With BCD_TIME_ALARM_EN: alarm 07:30, alarm_on = 1, set 07:29:59, then tick -> alarm_ring = 1. Ring holds until alarm_ack, then returns to 0. With alarm_on = 0 at the same point -> no ring.

Source files
------------

// File: rtl/bcd_time_counter.sv
// 24-hour packed-BCD wall clock advanced by synchronised rising edges of sec_clk.
// Define BCD_TIME_ALARM_EN to build the alarm registers and alarm_ring.
module bcd_time_counter #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] RESET_HH    = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sec_clk,
  input  logic       hold,
  input  logic       set_load,
  input  logic [7:0] set_hh,
  input  logic [7:0] set_mm,
  input  logic [7:0] set_ss,
  input  logic       alarm_load,
  input  logic [7:0] alarm_hh,
  input  logic [7:0] alarm_mm,
  input  logic       alarm_on,
  input  logic       alarm_ack,
  output logic [7:0] hours,
  output logic [7:0] minutes,
  output logic [7:0] seconds,
  output logic       sec_tick,
  output logic       day_pulse,
  output logic       set_err,
  output logic       alarm_ring
);

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic ok_ms(input logic [7:0] v);
    return (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9);
  endfunction

  // Units <= 9 makes a plain packed compare against 8'h23 exact.
  function automatic logic ok_hh(input logic [7:0] v);
    return (v[3:0] <= 4'd9) && (v <= 8'h23);
  endfunction

  logic [SYNC_STAGES-1:0] sync;
  logic                   hist;
  logic                   tick;
  logic                   advance;
  logic                   set_ok;
  logic                   err;
  logic                   ss_wrap;
  logic                   mm_wrap;
  logic                   hh_wrap;
  logic                   midnight;
  logic [7:0]             nxt_hh;
  logic [7:0]             nxt_mm;
  logic [7:0]             nxt_ss;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync <= '0;
      hist <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], sec_clk};
      hist <= sync[SYNC_STAGES-1];
    end
  end

  assign tick     = sync[SYNC_STAGES-1] & ~hist;
  assign advance  = tick & ~hold & ~set_load;
  assign set_ok   = ok_hh(set_hh) & ok_ms(set_mm) & ok_ms(set_ss);

  assign ss_wrap  = seconds == 8'h59;
  assign mm_wrap  = minutes == 8'h59;
  assign hh_wrap  = hours == 8'h23;
  assign midnight = ss_wrap & mm_wrap & hh_wrap;

  assign nxt_ss = ss_wrap ? 8'h00 : bcd_inc(seconds);
  assign nxt_mm = !ss_wrap ? minutes
                : mm_wrap  ? 8'h00
                : bcd_inc(minutes);
  assign nxt_hh = !(ss_wrap && mm_wrap) ? hours
                : hh_wrap               ? 8'h00
                : bcd_inc(hours);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hours     <= RESET_HH;
      minutes   <= 8'h00;
      seconds   <= 8'h00;
      sec_tick  <= 1'b0;
      day_pulse <= 1'b0;
      set_err   <= 1'b0;
    end else begin
      sec_tick  <= advance;
      day_pulse <= advance & midnight;
      set_err   <= err;
      unique case (1'b1)
        set_load && set_ok: begin
          hours   <= set_hh;
          minutes <= set_mm;
          seconds <= set_ss;
        end
        advance: begin
          hours   <= nxt_hh;
          minutes <= nxt_mm;
          seconds <= nxt_ss;
        end
        default: ;
      endcase
    end
  end

`ifdef BCD_TIME_ALARM_EN
  logic [7:0] al_hh;
  logic [7:0] al_mm;
  logic       alarm_ok;
  logic       match;

  assign alarm_ok = ok_hh(alarm_hh) & ok_ms(alarm_mm);
  assign err      = (set_load & ~set_ok) | (alarm_load & ~alarm_ok);
  // Compare against the value being ticked into, so a load never rings.
  assign match    = {nxt_hh, nxt_mm, nxt_ss} == {al_hh, al_mm, 8'h00};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      al_hh      <= 8'h00;
      al_mm      <= 8'h00;
      alarm_ring <= 1'b0;
    end else begin
      if (alarm_load && alarm_ok) begin
        al_hh <= alarm_hh;
        al_mm <= alarm_mm;
      end
      if (alarm_ack || !alarm_on)
        alarm_ring <= 1'b0;
      else if (advance && match)
        alarm_ring <= 1'b1;
    end
  end
`else
  logic unused_alarm;

  assign unused_alarm = ^{alarm_load, alarm_hh, alarm_mm,
                          alarm_on, alarm_ack};
  assign err          = set_load & ~set_ok;
  assign alarm_ring   = 1'b0;
`endif

endmodule
